branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 103 ++++++++++
 tb/tb_branch_predictor.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, next-PC select
// and saturating branch/misprediction statistics counters.
module branch_predictor #(
  parameter int addrWidth = 16,
  parameter int IDX_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Stall,
  input  logic                 Hcf,
  input  logic [addrWidth-1:0] IF_pc,
  input  logic                 EXE_update,
  input  logic [addrWidth-1:0] EXE_pc,
  input  logic                 EXE_taken,
  input  logic [addrWidth-1:0] EXE_Target_pc,
  input  logic                 EXE_pred_taken,
  input  logic [addrWidth-1:0] EXE_pred_target,
  output logic [1:0]           PCSel,
  output logic [addrWidth-1:0] Predict_Target_pc,
  output logic                 IF_pred_taken,
  output logic [15:0]          branch_cnt,
  output logic [15:0]          mispredict_cnt
);

  localparam int unsigned ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_W = addrWidth - IDX_BITS - 2;

  typedef enum logic [1:0] {
    PC_PLUS_4     = 2'd0,
    IF_P_T_PC     = 2'd1,
    EXE_T_PC      = 2'd2,
    EXE_PC_PLUS_4 = 2'd3
  } pc_sel_e;

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [addrWidth-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, exe_idx;
  logic [TAG_W-1:0]    if_tag, exe_tag;
  logic                if_hit, exe_hit, mispredict, upd;
  pc_sel_e             sel;
  logic                unused_pc_bits;

  assign if_idx  = IF_pc[IDX_BITS+1:2];
  assign exe_idx = EXE_pc[IDX_BITS+1:2];
  assign if_tag  = IF_pc[addrWidth-1:IDX_BITS+2];
  assign exe_tag = EXE_pc[addrWidth-1:IDX_BITS+2];
  assign unused_pc_bits = ^{IF_pc[1:0], EXE_pc[1:0]};

  assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign exe_hit = valid_q[exe_idx] && (tag_q[exe_idx] == exe_tag);

  assign IF_pred_taken     = if_hit & ctr_q[if_idx][1];
  assign Predict_Target_pc = target_q[if_idx];

  assign mispredict = EXE_update &
                      ((EXE_taken != EXE_pred_taken) |
                       (EXE_taken & EXE_pred_taken & (EXE_Target_pc != EXE_pred_target)));

  assign upd = EXE_update & ~Stall & ~Hcf;

  always_comb begin
    sel = PC_PLUS_4;
    if (mispredict && EXE_taken)       sel = EXE_T_PC;
    else if (mispredict && !EXE_taken) sel = EXE_PC_PLUS_4;
    else if (IF_pred_taken)            sel = IF_P_T_PC;
  end

  assign PCSel = sel;

  // Lookups read the registered table, so an entry written this cycle is seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd) begin
      if (exe_hit) begin
        if (EXE_taken) begin
          if (ctr_q[exe_idx] != 2'b11) ctr_q[exe_idx] <= ctr_q[exe_idx] + 2'd1;
          target_q[exe_idx] <= EXE_Target_pc;
        end else if (ctr_q[exe_idx] != 2'b00) begin
          ctr_q[exe_idx] <= ctr_q[exe_idx] - 2'd1;
        end
      end else if (EXE_taken) begin
        valid_q[exe_idx]  <= 1'b1;
        tag_q[exe_idx]    <= exe_tag;
        target_q[exe_idx] <= EXE_Target_pc;
        ctr_q[exe_idx]    <= 2'b10;
      end
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 16'd1;
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, training,
// aliasing, stall/halt gating and statistics saturation.
module tb_branch_predictor;

  localparam logic [1:0] SEL_PC4   = 2'd0;
  localparam logic [1:0] SEL_IFP   = 2'd1;
  localparam logic [1:0] SEL_EXET  = 2'd2;
  localparam logic [1:0] SEL_EXEP4 = 2'd3;

  logic        clk = 1'b0;
  logic        rst, Stall, Hcf, EXE_update, EXE_taken, EXE_pred_taken;
  logic [15:0] IF_pc, EXE_pc, EXE_Target_pc, EXE_pred_target;
  logic [1:0]  PCSel;
  logic [15:0] Predict_Target_pc, branch_cnt, mispredict_cnt;
  logic        IF_pred_taken;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  branch_predictor #(.addrWidth(16), .IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Hcf(Hcf), .IF_pc(IF_pc),
    .EXE_update(EXE_update), .EXE_pc(EXE_pc), .EXE_taken(EXE_taken),
    .EXE_Target_pc(EXE_Target_pc), .EXE_pred_taken(EXE_pred_taken),
    .EXE_pred_target(EXE_pred_target), .PCSel(PCSel),
    .Predict_Target_pc(Predict_Target_pc), .IF_pred_taken(IF_pred_taken),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                       input logic ptaken, input logic [15:0] ptgt,
                       input logic stall, input logic hcf);
    EXE_update      = 1'b1;
    EXE_pc          = pc;
    EXE_taken       = taken;
    EXE_Target_pc   = tgt;
    EXE_pred_taken  = ptaken;
    EXE_pred_target = ptgt;
    Stall           = stall;
    Hcf             = hcf;
    #1;
  endtask

  task automatic idle;
    EXE_update = 1'b0;
    Stall      = 1'b0;
    Hcf        = 1'b0;
    #1;
  endtask

  task automatic counts(input string tag, input logic [15:0] bc, input logic [15:0] mc);
    check({tag, "_bcnt"}, {16'd0, branch_cnt}, {16'd0, bc});
    check({tag, "_mcnt"}, {16'd0, mispredict_cnt}, {16'd0, mc});
  endtask

  // One resolved update at 0x0040 (IF also looking at 0x0040), then the prediction afterwards.
  task automatic train40(input string tag, input logic taken, input logic [15:0] tgt,
                         input logic ptaken, input logic [15:0] ptgt,
                         input logic [1:0] exp_sel, input logic exp_pred);
    IF_pc = 16'h0040;
    drive(16'h0040, taken, tgt, ptaken, ptgt, 1'b0, 1'b0);
    check({tag, "_sel"}, {30'd0, PCSel}, {30'd0, exp_sel});
    tick();
    idle();
    check({tag, "_pred"}, {31'd0, IF_pred_taken}, {31'd0, exp_pred});
  endtask

  initial begin
    rst = 1'b1;
    IF_pc = 16'h0040;
    drive(16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    idle();

    check("rst_pred", {31'd0, IF_pred_taken}, 32'd0);
    check("rst_sel",  {30'd0, PCSel}, {30'd0, SEL_PC4});
    counts("rst", 16'd0, 16'd0);

    // Allocate on a taken miss; same-cycle lookup still sees the old (empty) entry.
    drive(16'h0040, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("alloc_sel", {30'd0, PCSel}, {30'd0, SEL_EXET});
    check("alloc_same_cycle_pred", {31'd0, IF_pred_taken}, 32'd0);
    tick();
    idle();
    check("alloc_pred", {31'd0, IF_pred_taken}, 32'd1);
    check("alloc_tgt", {16'd0, Predict_Target_pc}, 32'h0100);
    check("alloc_sel_ifp", {30'd0, PCSel}, {30'd0, SEL_IFP});
    counts("alloc", 16'd1, 16'd1);

    // Counter 10 -> 01 -> 00 (floor) -> 01 -> 10.
    train40("nt1", 1'b0, 16'h0000, 1'b1, 16'h0100, SEL_EXEP4, 1'b0);
    train40("nt2", 1'b0, 16'h0000, 1'b1, 16'h0100, SEL_EXEP4, 1'b0);
    train40("t1",  1'b1, 16'h0100, 1'b0, 16'h0000, SEL_EXET,  1'b0);
    train40("t2",  1'b1, 16'h0100, 1'b0, 16'h0000, SEL_EXET,  1'b1);
    counts("floor", 16'd5, 16'd5);

    // Wrong target is a mispredict; target gets replaced, counter -> 11.
    train40("tgt_mis", 1'b1, 16'h0200, 1'b1, 16'h0100, SEL_EXET, 1'b1);
    check("tgt_new", {16'd0, Predict_Target_pc}, 32'h0200);
    // Correct prediction, counter stays 11 (ceiling), then 10, 01.
    train40("ok",  1'b1, 16'h0200, 1'b1, 16'h0200, SEL_IFP,   1'b1);
    train40("nt3", 1'b0, 16'h0000, 1'b1, 16'h0200, SEL_EXEP4, 1'b1);
    train40("nt4", 1'b0, 16'h0000, 1'b1, 16'h0200, SEL_EXEP4, 1'b0);
    counts("ceil", 16'd9, 16'd8);

    // Alias 0x0080 shares index 0 with 0x0040 and evicts it.
    train40("retrain", 1'b1, 16'h0200, 1'b0, 16'h0000, SEL_EXET, 1'b1);
    IF_pc = 16'h0040;
    drive(16'h0080, 1'b1, 16'h0300, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("alias_sel", {30'd0, PCSel}, {30'd0, SEL_EXET});
    tick();
    idle();
    check("alias_old_miss", {31'd0, IF_pred_taken}, 32'd0);
    IF_pc = 16'h0080;
    #1;
    check("alias_new_pred", {31'd0, IF_pred_taken}, 32'd1);
    check("alias_new_tgt", {16'd0, Predict_Target_pc}, 32'h0300);
    counts("alias", 16'd11, 16'd10);

    // Stall and halt: select still reacts, nothing is written.
    IF_pc = 16'h0044;
    drive(16'h0044, 1'b1, 16'h0400, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("stall_sel", {30'd0, PCSel}, {30'd0, SEL_EXET});
    tick();
    idle();
    check("stall_no_alloc", {31'd0, IF_pred_taken}, 32'd0);
    counts("stall", 16'd11, 16'd10);
    IF_pc = 16'h0080;
    drive(16'h0080, 1'b0, 16'h0000, 1'b1, 16'h0300, 1'b0, 1'b1);
    check("hcf_sel", {30'd0, PCSel}, {30'd0, SEL_EXEP4});
    tick();
    tick();
    idle();
    check("hcf_ctr_kept", {31'd0, IF_pred_taken}, 32'd1);
    counts("hcf", 16'd11, 16'd10);

    // Not-taken miss, correctly predicted: counted, table untouched.
    IF_pc = 16'h0048;
    drive(16'h0048, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("ntmiss_sel", {30'd0, PCSel}, {30'd0, SEL_PC4});
    tick();
    idle();
    check("ntmiss_pred", {31'd0, IF_pred_taken}, 32'd0);
    counts("ntmiss", 16'd12, 16'd10);

    // Statistics saturation.
    IF_pc = 16'h0080;
    drive(16'h0048, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("sat_sel", {30'd0, PCSel}, {30'd0, SEL_IFP});
    repeat (65536) @(posedge clk);
    @(negedge clk);
    idle();
    counts("sat", 16'hFFFF, 16'd10);
    drive(16'h0048, 1'b1, 16'h0500, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    idle();
    counts("sat_mis", 16'hFFFF, 16'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
